// File: rtl/signal_analyzer_pkg.sv
// Shared constants for the signal analyzer: FSM encoding and default
// crossing thresholds for the 32-bit signal-generator sample format.
package signal_analyzer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_SYNC    = 2'd2;
  localparam logic [1:0] ST_MEASURE = 2'd3;

  localparam int          DEFAULT_DATA_W = 32;
  localparam logic [31:0] MID            = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_HYST   = 32'h0100_0000;

endpackage

// File: rtl/signal_analyzer_crossing.sv
// Hysteresis comparator: flags low events and rising crossings (first high
// event after a low event) on accepted samples.
module crossing_detector #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] HYST   = DATA_W'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              low_evt,
  output logic              rise_evt
);

  // Thresholds are fixed at elaboration; HYST < MID keeps both free of wrap.
  localparam logic [DATA_W-1:0] MID_W   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] THR_LO  = MID_W - HYST;
  localparam logic [DATA_W-1:0] THR_HI  = MID_W + HYST;

  logic r_armed;
  logic w_high;

  assign low_evt  = sample_valid && (sample < THR_LO);
  assign w_high   = sample_valid && (sample >= THR_HI);
  assign rise_evt = w_high && r_armed;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed <= 1'b0;
    end else if (low_evt) begin
      r_armed <= 1'b1;
    end else if (rise_evt) begin
      r_armed <= 1'b0;
    end
  end

endmodule

// File: rtl/signal_analyzer.sv
// Period and min/max analyzer for a periodic waveform, publishing one result
// per rising-crossing-to-rising-crossing window over a valid/ready handshake.
module signal_analyzer
  import signal_analyzer_pkg::*;
#(
  parameter int                DATA_W = DEFAULT_DATA_W,
  parameter int                CNT_W  = 32,
  parameter logic [DATA_W-1:0] HYST   = DATA_W'(DEFAULT_HYST)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic              result_ready,
  output logic              result_valid,
  output logic [CNT_W-1:0]  period,
  output logic [DATA_W-1:0] sample_min,
  output logic [DATA_W-1:0] sample_max,
  output logic              dropped,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_run_min;
  logic [DATA_W-1:0] r_run_max;
  logic              r_result_valid;
  logic [CNT_W-1:0]  r_period;
  logic [DATA_W-1:0] r_sample_min;
  logic [DATA_W-1:0] r_sample_max;
  logic              r_dropped;
  logic              r_timeout;

  logic              w_accept;
  logic              w_low;
  logic              w_rise;
  logic              w_publish;
  logic              w_consume;
  logic              w_load;
  logic              w_drop;
  logic [CNT_W-1:0]  w_count_next;

  assign w_accept = sample_valid && (r_state != ST_IDLE);

  crossing_detector #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_crossing (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .sample_valid (w_accept),
    .low_evt      (w_low),
    .rise_evt     (w_rise)
  );

  assign w_publish    = enable && (r_state == ST_MEASURE) && w_rise;
  assign w_consume    = r_result_valid && result_ready;
  assign w_load       = w_publish && (!r_result_valid || w_consume);
  assign w_drop       = w_publish && r_result_valid && !w_consume;
  assign w_count_next = r_count + CNT_ONE;

  // Window tracking FSM; enable low wins over every other transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_run_min <= '0;
      r_run_max <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (!enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_ARM;
          ST_ARM: begin
            if (w_low) r_state <= ST_SYNC;
          end
          ST_SYNC: begin
            if (w_rise) begin
              r_state   <= ST_MEASURE;
              r_count   <= CNT_ONE;
              r_run_min <= sample;
              r_run_max <= sample;
            end
          end
          default: begin
            if (w_rise) begin
              r_count   <= CNT_ONE;
              r_run_min <= sample;
              r_run_max <= sample;
            end else if (w_accept) begin
              r_count <= w_count_next;
              if (w_count_next == CNT_MAX) begin
                r_timeout <= 1'b1;
                r_state   <= ST_ARM;
              end else begin
                if (sample < r_run_min) r_run_min <= sample;
                if (sample > r_run_max) r_run_max <= sample;
              end
            end
          end
        endcase
      end
    end
  end

  // Result holding registers; a completed window is lost only while an
  // unread result is held and not being consumed on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result_valid <= 1'b0;
      r_period       <= '0;
      r_sample_min   <= '0;
      r_sample_max   <= '0;
      r_dropped      <= 1'b0;
    end else begin
      if (w_load) begin
        r_result_valid <= 1'b1;
        r_period       <= r_count;
        r_sample_min   <= r_run_min;
        r_sample_max   <= r_run_max;
      end else if (w_consume) begin
        r_result_valid <= 1'b0;
      end
      if (w_drop) begin
        r_dropped <= 1'b1;
      end else if (w_consume) begin
        r_dropped <= 1'b0;
      end
    end
  end

  assign result_valid = r_result_valid;
  assign period       = r_period;
  assign sample_min   = r_sample_min;
  assign sample_max   = r_sample_max;
  assign dropped      = r_dropped;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_signal_analyzer.sv
// Directed self-checking bench for signal_analyzer: saw/square periods,
// sparse valid, backpressure/drop, counter timeout and mid-window reset.
module tb_signal_analyzer;
  import signal_analyzer_pkg::*;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] sample;
  logic        sample_valid;
  logic        result_ready;
  logic        result_valid;
  logic [31:0] period;
  logic [31:0] sample_min;
  logic [31:0] sample_max;
  logic        dropped;
  logic        timeout;

  logic        enable8;
  logic [31:0] sample8;
  logic        sample_valid8;
  logic        result_ready8;
  logic        result_valid8;
  logic [7:0]  period8;
  logic [31:0] sample_min8;
  logic [31:0] sample_max8;
  logic        dropped8;
  logic        timeout8;

  int n_checks = 0;
  int n_errors = 0;

  signal_analyzer u_dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample       (sample),
    .sample_valid (sample_valid),
    .result_ready (result_ready),
    .result_valid (result_valid),
    .period       (period),
    .sample_min   (sample_min),
    .sample_max   (sample_max),
    .dropped      (dropped),
    .timeout      (timeout)
  );

  signal_analyzer #(.CNT_W(8)) u_dut8 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable8),
    .sample       (sample8),
    .sample_valid (sample_valid8),
    .result_ready (result_ready8),
    .result_valid (result_valid8),
    .period       (period8),
    .sample_min   (sample_min8),
    .sample_max   (sample_max8),
    .dropped      (dropped8),
    .timeout      (timeout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present inputs at the falling edge, return just after the next rising edge.
  task automatic drive(input logic v, input logic [31:0] d);
    @(negedge clk);
    sample_valid = v;
    sample       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [31:0] d);
    @(negedge clk);
    sample_valid8 = v;
    sample8       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    enable        = 1'b0;
    enable8       = 1'b0;
    sample_valid  = 1'b0;
    sample_valid8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] wave(input int mode, input int n);
    logic [3:0] ph;
    ph = n[3:0];
    if (mode == 0) return {ph, 28'h0};
    return ph[3] ? 32'hFFFF_FFFF : 32'h0;
  endfunction

  // Runs a waveform until three results are seen, checking each and the gap.
  task automatic run_wave(input int mode, input bit alt, input int exp_gap, input string name);
    int          n;
    int          results;
    int          last;
    logic        v;
    logic [31:0] exp_max;
    n       = 0;
    results = 0;
    last    = 0;
    exp_max = (mode == 0) ? 32'hF000_0000 : 32'hFFFF_FFFF;
    for (int cyc = 0; cyc < 2000 && results < 3; cyc++) begin
      v = alt ? (cyc % 2 == 0) : 1'b1;
      drive(v, wave(mode, n));
      if (v) n++;
      if (result_valid) begin
        results++;
        check({name, "_period"}, period, 32'd16);
        check({name, "_min"}, sample_min, 32'h0);
        check({name, "_max"}, sample_max, exp_max);
        check({name, "_dropped"}, {31'b0, dropped}, 32'd0);
        if (results > 1) check({name, "_gap"}, cyc - last, exp_gap);
        last = cyc;
      end
    end
    check({name, "_results"}, results, 32'd3);
  endtask

  initial begin
    int n;
    int found;
    reset         = 1'b0;
    enable        = 1'b0;
    enable8       = 1'b0;
    sample        = '0;
    sample8       = '0;
    sample_valid  = 1'b0;
    sample_valid8 = 1'b0;
    result_ready  = 1'b1;
    result_ready8 = 1'b1;
    #12;
    check("rst_valid", {31'b0, result_valid}, 32'd0);
    check("rst_period", period, 32'd0);
    check("rst_min", sample_min, 32'd0);
    check("rst_max", sample_max, 32'd0);
    check("rst_dropped", {31'b0, dropped}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    enable = 1'b1;
    run_wave(0, 1'b0, 16, "saw");

    do_reset();
    enable = 1'b1;
    run_wave(1, 1'b0, 16, "square");

    do_reset();
    enable = 1'b1;
    run_wave(0, 1'b1, 32, "saw_alt");

    // Backpressure: window of 16 is held, following window of 12 is dropped.
    do_reset();
    enable       = 1'b1;
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'hC000_0000);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h1000_0000);
    check("bp_valid_before", {31'b0, result_valid}, 32'd0);
    drive(1'b1, 32'hFFFF_FFFF);
    check("bp_valid_first", {31'b0, result_valid}, 32'd1);
    check("bp_dropped_first", {31'b0, dropped}, 32'd0);
    for (int i = 0; i < 7; i++) drive(1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h2000_0000);
    drive(1'b1, 32'hE000_0000);
    check("bp_valid_held", {31'b0, result_valid}, 32'd1);
    check("bp_period_held", period, 32'd16);
    check("bp_min_held", sample_min, 32'h1000_0000);
    check("bp_max_held", sample_max, 32'hC000_0000);
    check("bp_dropped", {31'b0, dropped}, 32'd1);
    result_ready = 1'b1;
    drive(1'b0, 32'h0);
    check("bp_valid_consumed", {31'b0, result_valid}, 32'd0);
    check("bp_dropped_cleared", {31'b0, dropped}, 32'd0);

    // Saturation on the 8-bit counter instance.
    do_reset();
    enable8 = 1'b1;
    drive8(1'b1, 32'h0);
    drive8(1'b1, 32'h0);
    drive8(1'b1, 32'hFFFF_FFFF);
    found = 0;
    for (int i = 1; i <= 400 && found == 0; i++) begin
      drive8(1'b1, 32'h8000_0000);
      if (timeout8) found = i;
    end
    check("to_sample_index", found, 32'd254);
    check("to_no_result", {31'b0, result_valid8}, 32'd0);
    check("to_state_arm", {30'b0, u_dut8.r_state}, {30'b0, ST_ARM});
    drive8(1'b1, 32'h8000_0000);
    check("to_pulse_width", {31'b0, timeout8}, 32'd0);
    check("to_period", {24'b0, period8}, 32'd0);

    // Reset at the 5th sample of a window, then resynchronise from scratch.
    do_reset();
    enable       = 1'b1;
    result_ready = 1'b0;
    for (int i = 0; i < 29; i++) drive(1'b1, wave(0, i));
    check("mr_valid_before", {31'b0, result_valid}, 32'd1);
    check("mr_period_before", period, 32'd16);
    @(negedge clk);
    sample = wave(0, 13);
    reset  = 1'b0;
    #1;
    check("mr_valid", {31'b0, result_valid}, 32'd0);
    check("mr_period", period, 32'd0);
    check("mr_min", sample_min, 32'd0);
    check("mr_max", sample_max, 32'd0);
    check("mr_dropped", {31'b0, dropped}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset        = 1'b1;
    result_ready = 1'b1;
    found = -1;
    n     = 14;
    for (int i = 0; i < 100 && found < 0; i++) begin
      drive(1'b1, wave(0, n));
      n++;
      if (result_valid) found = i;
    end
    check("mr_first_result_idx", found, 32'd27);
    check("mr_first_period", period, 32'd16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/signal_analyzer.md
SIGNAL_ANALYZER -- requirements
Module: signal_analyzer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample width.
REQ-002 SHALL have parameter CNT_W, default 32, period counter width.
REQ-003 SHALL have parameter HYST, default 32'h0100_0000, crossing hysteresis around midpoint 2^(DATA_W-1).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  1 = run; 0 = return to IDLE next cycle.
REQ-007 SHALL have port sample  in  DATA_W  unsigned waveform sample (signal generator output format).
REQ-008 SHALL have port sample_valid  in  1  sample accepted on any clk edge where high and state != IDLE.
REQ-009 SHALL have port result_ready  in  1  consumer accepts result.
REQ-010 SHALL have port result_valid  out  1  period/min/max registers hold an unread result.
REQ-011 SHALL have port period  out  CNT_W  accepted samples between consecutive rising crossings.
REQ-012 SHALL have port sample_min  out  DATA_W  minimum sample in the measured window.
REQ-013 SHALL have port sample_max  out  DATA_W  maximum sample in the measured window.
REQ-014 SHALL have port dropped  out  1  sticky; a result was lost while result_valid was high.
REQ-015 SHALL have port timeout  out  1  one-cycle pulse on period counter saturation.

Function
REQ-016 SHALL implement FSM IDLE -> ARM -> SYNC -> MEASURE; enable=1 moves IDLE->ARM; enable=0 forces IDLE from any state, keeping result registers.
REQ-017 Low event: accepted sample < MID-HYST; high event: accepted sample >= MID+HYST; rising crossing = first high event after a low event.
REQ-018 ARM SHALL go to SYNC on a low event; SYNC SHALL go to MEASURE on a rising crossing, loading count=1, min=max=that sample.
REQ-019 In MEASURE each accepted non-crossing sample SHALL increment count and update running min/max; cycles without sample_valid SHALL change nothing.
REQ-020 On a rising crossing in MEASURE the window (start crossing inclusive, ending crossing exclusive) SHALL be published: period=count, min/max=running values; count reloads to 1, min/max to the crossing sample, state stays MEASURE.
REQ-021 result_valid SHALL rise the cycle after the ending crossing sample is accepted (latency 1).
REQ-022 A result SHALL be consumed on a clk edge with result_valid & result_ready; result_valid then falls unless a new result publishes on the same edge, in which case the new result loads and result_valid stays high.
REQ-023 If a result completes while result_valid=1 and result_ready=0, the held result SHALL be kept, the new one discarded, dropped set to 1.
REQ-024 dropped SHALL clear on the next consume handshake; a drop on that same edge SHALL leave it set.
REQ-025 Count SHALL saturate at 2^CNT_W-1; reaching it SHALL pulse timeout, publish nothing, and return to ARM.
REQ-026 Comparisons SHALL be unsigned; MID-HYST and MID+HYST SHALL be computed at DATA_W without wrap (HYST < MID required).

Reset
REQ-027 reset low SHALL asynchronously force state=IDLE, count=0, running min/max=0, result_valid=0, period=0, sample_min=0, sample_max=0, dropped=0, timeout=0.
REQ-028 Reset mid-measurement SHALL discard the partial window; after release a fresh low event and rising crossing are needed before counting.

Structure
REQ-029 Package signal_analyzer_pkg SHALL hold the FSM state encoding, MID constant, and default HYST.
REQ-030 Hysteresis comparator SHALL be sub-module crossing_detector (sample, sample_valid in; low_evt, rise_evt out; armed flag inside).

Verification
REQ-031 Saw: sample=(n*32'h1000_0000) each cycle, ready=1 -> repeated period=16, sample_min=0, sample_max=32'hF000_0000.
REQ-032 Square: 8 samples 0, 8 samples 32'hFFFF_FFFF repeating -> period=16, min=0, max=32'hFFFF_FFFF, dropped=0.
REQ-033 Saw of REQ-031 with sample_valid on alternate cycles -> period still 16, result_valid spacing 32 clk.
REQ-034 result_ready=0 across two windows -> first result held unchanged, dropped=1; one handshake -> result_valid=0, dropped=0.
REQ-035 CNT_W=8, constant 32'h8000_0000 after sync -> timeout pulse after count hits 255, state ARM, no result.
REQ-036 reset low at 5th sample of a window -> all outputs 0 immediately; after release first result only after new low event and two crossings.
